// File: rtl/conf_int_mul__pkg.sv
// Shared constants for the multiplier wrapper and its downstream dot-product stage.
// Holds the product width and the accumulator FSM state encodings.
package conf_int_mul__pkg;

    localparam int MUL_FULL_BITWIDTH = 24;
    localparam int PROD_BITWIDTH     = 2 * MUL_FULL_BITWIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

endpackage

// File: rtl/conf_int_mul__sat_add.sv
// Combinational unsigned saturating adder: accumulator plus zero-extended product.
// Clamps to all ones and flags when the sum carries out of the accumulator width.
module conf_int_mul__sat_add #(
    parameter int ACC_BITWIDTH  = 56,
    parameter int PROD_BITWIDTH = 48
) (
    input  logic [ACC_BITWIDTH-1:0]  i_acc,
    input  logic [PROD_BITWIDTH-1:0] i_prod,
    output logic [ACC_BITWIDTH-1:0]  o_sum,
    output logic                     o_sat
);

    logic [ACC_BITWIDTH:0] w_prodExt;
    logic [ACC_BITWIDTH:0] w_full;

    assign w_prodExt = {{(ACC_BITWIDTH + 1 - PROD_BITWIDTH){1'b0}}, i_prod};
    assign w_full    = {1'b0, i_acc} + w_prodExt;

    assign o_sat = w_full[ACC_BITWIDTH];
    assign o_sum = o_sat ? {ACC_BITWIDTH{1'b1}} : w_full[ACC_BITWIDTH-1:0];

endmodule

// File: rtl/conf_int_mul__dot_acc_stage.sv
// Dot-product reduction stage: sums a run of LEN unsigned products with saturation
// and presents the result on a valid/ready port. All outputs decode from registers.
module conf_int_mul__dot_acc_stage
    import conf_int_mul__pkg::*;
#(
    parameter int ACC_BITWIDTH = 56,
    parameter int LEN_BITWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_BITWIDTH-1:0]  len,
    input  logic                     prod_vld,
    input  logic [PROD_BITWIDTH-1:0] prod,
    output logic                     prod_rdy,
    output logic                     sum_vld,
    output logic [ACC_BITWIDTH-1:0]  sum,
    input  logic                     sum_rdy,
    output logic                     busy,
    output logic                     ovf
);

    logic [1:0]              r_state;
    logic [LEN_BITWIDTH-1:0] r_count;
    logic [ACC_BITWIDTH-1:0] r_sum;
    logic                    r_ovf;

    logic                    w_accept;
    logic [ACC_BITWIDTH-1:0] w_addSum;
    logic                    w_addSat;

    conf_int_mul__sat_add #(
        .ACC_BITWIDTH  (ACC_BITWIDTH),
        .PROD_BITWIDTH (PROD_BITWIDTH)
    ) u_satAdd (
        .i_acc  (r_sum),
        .i_prod (prod),
        .o_sum  (w_addSum),
        .o_sat  (w_addSat)
    );

    assign w_accept = prod_vld && (r_state == ACC);

    // A start in IDLE opens a new run; an empty run goes straight to HOLD with a zero sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_count <= len;
                        r_sum   <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= (len != '0) ? ACC : HOLD;
                    end
                end
                ACC: begin
                    if (w_accept) begin
                        r_sum   <= w_addSum;
                        r_ovf   <= r_ovf | w_addSat;
                        r_count <= r_count - 1'b1;
                        if (r_count == LEN_BITWIDTH'(1)) begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (sum_rdy) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign prod_rdy = (r_state == ACC);
    assign sum_vld  = (r_state == HOLD);
    assign busy     = (r_state != IDLE);
    assign sum      = r_sum;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_conf_int_mul__dot_acc_stage.sv
// Self-checking bench for the dot-product stage: a run-level reference model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_conf_int_mul__dot_acc_stage;

    localparam int ACC_W  = 48;
    localparam int LEN_W  = 8;
    localparam int PROD_W = 48;
    localparam logic [63:0] SUM_MAX = (64'd1 << ACC_W) - 64'd1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic              prod_vld = 1'b0;
    logic [PROD_W-1:0] prod = '0;
    logic              prod_rdy;
    logic              sum_vld;
    logic [ACC_W-1:0]  sum;
    logic              sum_rdy = 1'b0;
    logic              busy;
    logic              ovf;

    int assertCount = 0;
    int failCount   = 0;

    conf_int_mul__dot_acc_stage #(
        .ACC_BITWIDTH (ACC_W),
        .LEN_BITWIDTH (LEN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .prod_vld (prod_vld),
        .prod     (prod),
        .prod_rdy (prod_rdy),
        .sum_vld  (sum_vld),
        .sum      (sum),
        .sum_rdy  (sum_rdy),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: tracks whether a run is open, whether a result is waiting,
    // how many beats remain, and the running total clamped to the accumulator range.
    bit          mInRun   = 1'b0;
    bit          mHasSum  = 1'b0;
    int          mLeft    = 0;
    logic [63:0] mTotal   = 64'd0;
    bit          mOvf     = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mInRun  = 1'b0;
            mHasSum = 1'b0;
            mLeft   = 0;
            mTotal  = 64'd0;
            mOvf    = 1'b0;
        end else if (mInRun) begin
            if (prod_vld) begin
                mTotal = mTotal + {16'd0, prod};
                if (mTotal > SUM_MAX) begin
                    mTotal = SUM_MAX;
                    mOvf   = 1'b1;
                end
                mLeft = mLeft - 1;
                if (mLeft == 0) begin
                    mInRun  = 1'b0;
                    mHasSum = 1'b1;
                end
            end
        end else if (mHasSum) begin
            if (sum_rdy) mHasSum = 1'b0;
        end else if (start) begin
            mTotal = 64'd0;
            mOvf   = 1'b0;
            mLeft  = int'(len);
            if (len == 0) mHasSum = 1'b1;
            else          mInRun  = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checkOutput("model prod_rdy", 64'(prod_rdy), 64'(mInRun));
            checkOutput("model sum_vld",  64'(sum_vld),  64'(mHasSum));
            checkOutput("model busy",     64'(busy),     64'(mInRun | mHasSum));
            checkOutput("model ovf",      64'(ovf),      64'(mOvf));
            checkOutput("model sum",      64'(sum),      mTotal);
        end
    end

    task automatic applyStimulus(input logic st, input logic [LEN_W-1:0] ln, input logic pv,
                                 input logic [PROD_W-1:0] pd, input logic sr);
        start    = st;
        len      = ln;
        prod_vld = pv;
        prod     = pd;
        sum_rdy  = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        #12;
        checkOutput("reset busy",     64'(busy),     64'd0);
        checkOutput("reset prod_rdy", 64'(prod_rdy), 64'd0);
        checkOutput("reset sum_vld",  64'(sum_vld),  64'd0);
        checkOutput("reset sum",      64'(sum),      64'd0);
        checkOutput("reset ovf",      64'(ovf),      64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idleCycle();

        // Normal run with output back-pressure
        applyStimulus(1'b1, 8'd3, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 48'd10, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 48'd20, 1'b0);
        checkOutput("run1 no early vld", 64'(sum_vld), 64'd0);
        applyStimulus(1'b0, '0, 1'b1, 48'd30, 1'b0);
        checkOutput("run1 sum_vld", 64'(sum_vld), 64'd1);
        checkOutput("run1 sum",     64'(sum),     64'd60);
        checkOutput("run1 ovf",     64'(ovf),     64'd0);
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            checkOutput("run1 held vld", 64'(sum_vld), 64'd1);
            checkOutput("run1 held sum", 64'(sum),     64'd60);
        end
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("run1 released vld",  64'(sum_vld), 64'd0);
        checkOutput("run1 released busy", 64'(busy),    64'd0);

        // Bubbles between beats
        applyStimulus(1'b1, 8'd2, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 48'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bubble prod_rdy", 64'(prod_rdy), 64'd1);
            applyStimulus(1'b0, '0, 1'b0, 48'd1234, 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b1, 48'd7, 1'b0);
        checkOutput("bubble sum", 64'(sum), 64'd12);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);

        // Empty run; product beats outside ACC must be ignored
        applyStimulus(1'b1, 8'd0, 1'b1, 48'd99, 1'b0);
        checkOutput("empty sum_vld",  64'(sum_vld),  64'd1);
        checkOutput("empty sum",      64'(sum),      64'd0);
        checkOutput("empty prod_rdy", 64'(prod_rdy), 64'd0);
        applyStimulus(1'b0, '0, 1'b1, 48'd99, 1'b0);
        checkOutput("empty sum stable", 64'(sum), 64'd0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);

        // Saturation, then the next start clears ovf
        applyStimulus(1'b1, 8'd2, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 48'h1, 1'b0);
        checkOutput("sat sum", 64'(sum), 64'hFFFF_FFFF_FFFF);
        checkOutput("sat ovf", 64'(ovf), 64'd1);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("sat ovf sticky in idle", 64'(ovf), 64'd1);
        applyStimulus(1'b1, 8'd1, 1'b0, '0, 1'b0);
        checkOutput("sat ovf cleared", 64'(ovf), 64'd0);
        applyStimulus(1'b0, '0, 1'b1, 48'd4, 1'b0);
        checkOutput("post-sat sum", 64'(sum), 64'd4);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);

        // start collisions in ACC and in HOLD
        applyStimulus(1'b1, 8'd2, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 8'd9, 1'b1, 48'd3, 1'b0);
        checkOutput("collide acc still running", 64'(prod_rdy), 64'd1);
        applyStimulus(1'b1, 8'd9, 1'b1, 48'd4, 1'b0);
        checkOutput("collide acc sum", 64'(sum), 64'd7);
        applyStimulus(1'b1, 8'd1, 1'b0, '0, 1'b1);
        checkOutput("collide hold busy", 64'(busy), 64'd0);
        idleCycle();
        checkOutput("collide stays idle", 64'(busy), 64'd0);
        applyStimulus(1'b1, 8'd1, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 48'd9, 1'b0);
        checkOutput("collide next run sum", 64'(sum), 64'd9);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);

        // Asynchronous reset between beats of a len=4 run
        applyStimulus(1'b1, 8'd4, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 48'd100, 1'b0);
        prod_vld = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst busy",     64'(busy),     64'd0);
        checkOutput("arst sum",      64'(sum),      64'd0);
        checkOutput("arst prod_rdy", 64'(prod_rdy), 64'd0);
        checkOutput("arst sum_vld",  64'(sum_vld),  64'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 48'd50, 1'b0);
            checkOutput("arst no sum_vld", 64'(sum_vld), 64'd0);
        end
        idleCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
